// File: rtl/i2c_slave_fifo.sv
// Byte buffering between i2c_slave and host logic: a show-ahead RX FIFO for received
// bytes and a show-ahead TX FIFO feeding master reads, each with level and sticky error flags.
module i2c_slave_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           data_o,
  input  logic                       data_o_valid,
  output logic [WIDTH-1:0]           data_i,
  output logic                       data_i_valid,
  input  logic                       data_i_ready,
  output logic [WIDTH-1:0]           rx_rdata,
  input  logic                       rx_rd_en,
  output logic                       rx_empty,
  output logic [$clog2(DEPTH):0]     rx_level,
  input  logic [WIDTH-1:0]           tx_wdata,
  input  logic                       tx_wr_en,
  output logic                       tx_full,
  output logic [$clog2(DEPTH):0]     tx_level,
  output logic                       rx_overflow,
  output logic                       tx_underrun,
  input  logic                       clr_flags
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] rx_mem [DEPTH];
  logic [WIDTH-1:0] tx_mem [DEPTH];

  logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [LW-1:0] rx_level_q, rx_level_d, tx_level_q, tx_level_d;
  logic          rx_overflow_q, rx_overflow_d, tx_underrun_q, tx_underrun_d;

  logic rx_full, tx_empty;
  logic rx_push, rx_pop, tx_push, tx_pop;
  logic rx_ovf_set, tx_und_set;

  assign rx_empty     = (rx_level_q == '0);
  assign rx_full      = (rx_level_q == LVL_FULL);
  assign tx_empty     = (tx_level_q == '0);
  assign tx_full      = (tx_level_q == LVL_FULL);
  assign rx_level     = rx_level_q;
  assign tx_level     = tx_level_q;
  assign rx_overflow  = rx_overflow_q;
  assign tx_underrun  = tx_underrun_q;
  assign data_i_valid = !tx_empty;

  // Head outputs are forced to zero when empty so stale memory never leaks out.
  assign rx_rdata = rx_empty ? '0 : rx_mem[rx_rptr_q];
  assign data_i   = tx_empty ? '0 : tx_mem[tx_rptr_q];

  // A push at full is still accepted when the same cycle frees a slot.
  assign rx_pop     = rx_rd_en && !rx_empty;
  assign rx_push    = data_o_valid && (!rx_full || rx_pop);
  assign rx_ovf_set = data_o_valid && rx_full && !rx_pop;

  assign tx_pop     = data_i_valid && data_i_ready;
  assign tx_push    = tx_wr_en && (!tx_full || tx_pop);
  assign tx_und_set = data_i_ready && tx_empty;

  always_comb begin
    rx_wptr_d  = rx_push ? rx_wptr_q + 1'b1 : rx_wptr_q;
    rx_rptr_d  = rx_pop  ? rx_rptr_q + 1'b1 : rx_rptr_q;
    tx_wptr_d  = tx_push ? tx_wptr_q + 1'b1 : tx_wptr_q;
    tx_rptr_d  = tx_pop  ? tx_rptr_q + 1'b1 : tx_rptr_q;
    rx_level_d = rx_level_q;
    tx_level_d = tx_level_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_level_d = rx_level_q + 1'b1;
      2'b01:   rx_level_d = rx_level_q - 1'b1;
      default: rx_level_d = rx_level_q;
    endcase
    case ({tx_push, tx_pop})
      2'b10:   tx_level_d = tx_level_q + 1'b1;
      2'b01:   tx_level_d = tx_level_q - 1'b1;
      default: tx_level_d = tx_level_q;
    endcase
    // Setting wins over a same-cycle clear so no event is silently lost.
    rx_overflow_d = rx_ovf_set ? 1'b1 : (clr_flags ? 1'b0 : rx_overflow_q);
    tx_underrun_d = tx_und_set ? 1'b1 : (clr_flags ? 1'b0 : tx_underrun_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wptr_q     <= '0;
      rx_rptr_q     <= '0;
      tx_wptr_q     <= '0;
      tx_rptr_q     <= '0;
      rx_level_q    <= '0;
      tx_level_q    <= '0;
      rx_overflow_q <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      rx_wptr_q     <= rx_wptr_d;
      rx_rptr_q     <= rx_rptr_d;
      tx_wptr_q     <= tx_wptr_d;
      tx_rptr_q     <= tx_rptr_d;
      rx_level_q    <= rx_level_d;
      tx_level_q    <= tx_level_d;
      rx_overflow_q <= rx_overflow_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  // Storage has no reset; validity is tracked entirely by the pointers and levels.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr_q] <= data_o;
    if (tx_push) tx_mem[tx_wptr_q] <= tx_wdata;
  end

endmodule
